// File: rtl/dac_pair_sequencer.sv
// dac_pair_sequencer: paces two 8-bit parallel DACs from 2-deep per-channel sample FIFOs,
// updating both data buses on each tick and strobing the DAC clocks after a fixed setup time.
module dac_pair_sequencer #(
    parameter int DIV   = 16,
    parameter int SETUP = 2,
    parameter int HI    = 3
) (
    input  logic       i_clk80,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic       i_mode_in,
    input  logic       i_clr_flags,
    input  logic [7:0] i_s1_data,
    input  logic       i_s1_valid,
    output logic       o_s1_ready,
    input  logic [7:0] i_s2_data,
    input  logic       i_s2_valid,
    output logic       o_s2_ready,
    output logic [7:0] o_dac1_db,
    output logic       o_dac1_clk,
    output logic [7:0] o_dac2_db,
    output logic       o_dac2_clk,
    output logic       o_dac_mode,
    output logic       o_tick,
    output logic       o_underrun1,
    output logic       o_underrun2
);
    localparam int CW   = $clog2(DIV);
    localparam int PMAX = (SETUP > HI) ? SETUP : HI;
    localparam int PW   = $clog2(PMAX + 1);

    if (DIV < 8 || DIV > 65535 || SETUP < 1 || HI < 1 || DIV < SETUP + HI + 2) begin : g_bad_params
        $error("dac_pair_sequencer: illegal DIV/SETUP/HI combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_ph, w_ph_nxt;
    logic [CW-1:0]   r_tcnt;
    logic            r_clk;
    logic            r_mode;
    logic            w_tick;
    logic [1:0][7:0] w_sdata;
    logic [1:0]      w_svalid;
    logic [1:0]      w_ready;
    logic [1:0][7:0] w_db;
    logic [1:0]      w_ur;

    assign w_sdata  = {i_s2_data, i_s1_data};
    assign w_svalid = {i_s2_valid, i_s1_valid};
    assign w_tick   = i_enable && (r_tcnt == CW'(DIV - 1));

    always_ff @(posedge i_clk80 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tcnt <= '0;
            r_mode <= 1'b0;
        end else begin
            r_tcnt <= (!i_enable || w_tick) ? '0 : r_tcnt + CW'(1);
            if (w_tick) r_mode <= i_mode_in;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [7:0] r_q0, r_q1, r_db;
        logic [1:0] r_fill;
        logic       r_ur;
        logic       w_push, w_pop;
        assign w_ready[c] = (r_fill != 2'd2);
        assign w_push     = w_svalid[c] & w_ready[c];
        assign w_pop      = w_tick & (r_fill != 2'd0);
        assign w_db[c]    = r_db;
        assign w_ur[c]    = r_ur;
        // A push racing a pop at fill 1 lands straight in the head slot.
        always_ff @(posedge i_clk80 or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_q0   <= '0;
                r_q1   <= '0;
                r_db   <= '0;
                r_fill <= '0;
                r_ur   <= 1'b0;
            end else begin
                if (w_pop) r_q0 <= (r_fill == 2'd2) ? r_q1 : w_sdata[c];
                else if (w_push && r_fill == 2'd0) r_q0 <= w_sdata[c];
                else if (w_push) r_q1 <= w_sdata[c];
                r_fill <= r_fill + {1'b0, w_push} - {1'b0, w_pop};
                if (w_pop) r_db <= r_q0;
                if (w_tick && r_fill == 2'd0) r_ur <= 1'b1;
                else if (i_clr_flags) r_ur <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk80 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_ph    <= '0;
            r_clk   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_clk   <= (w_state_nxt == S_STROBE);
        end
    end

    // Once a sequence starts it always runs SETUP then STROBE to completion.
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        case (r_state)
            S_IDLE: if (w_tick) begin
                w_state_nxt = S_SETUP;
                w_ph_nxt    = '0;
            end
            S_SETUP: if (r_ph == PW'(SETUP - 1)) begin
                w_state_nxt = S_STROBE;
                w_ph_nxt    = '0;
            end else w_ph_nxt = r_ph + PW'(1);
            S_STROBE: if (r_ph == PW'(HI - 1)) begin
                w_state_nxt = i_enable ? S_HOLD : S_IDLE;
                w_ph_nxt    = '0;
            end else w_ph_nxt = r_ph + PW'(1);
            S_HOLD: if (!i_enable) w_state_nxt = S_IDLE;
            else if (w_tick) begin
                w_state_nxt = S_SETUP;
                w_ph_nxt    = '0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_s1_ready  = w_ready[0];
    assign o_s2_ready  = w_ready[1];
    assign o_dac1_db   = w_db[0];
    assign o_dac2_db   = w_db[1];
    assign o_dac1_clk  = r_clk;
    assign o_dac2_clk  = r_clk;
    assign o_dac_mode  = r_mode;
    assign o_tick      = w_tick;
    assign o_underrun1 = w_ur[0];
    assign o_underrun2 = w_ur[1];
endmodule
